// File: rtl/exc_redirect_ctrl_pkg.sv
// Shared constants for the exception/ERET redirect sequencer.
// State encodings and the fixed exception entry vector.
package exc_redirect_ctrl_pkg;

    localparam logic [1:0] EXR_IDLE     = 2'd0;
    localparam logic [1:0] EXR_DRAIN    = 2'd1;
    localparam logic [1:0] EXR_REDIRECT = 2'd2;

    localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;

endpackage

// File: rtl/exc_redirect_ctrl_inflight_counter.sv
// Up/down count of in-flight requests on an SRAM-like port.
// Saturates at MAX_OUTSTANDING and floors at zero.
module inflight_counter #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             fire,
    input  logic             rsp,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: a request and a response in the same cycle cancel.
    always_comb begin
        cnt_d = cnt_q;
        if (fire && !rsp && cnt_q != MAX_C) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rsp && !fire && cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/exc_redirect_ctrl.sv
// Flushes on a WB exception/ERET, drains stale fetch responses,
// then offers the redirect PC to pre-IF until it is acknowledged.
module exc_redirect_ctrl
    import exc_redirect_ctrl_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ws_exc_valid,
    input  logic [31:0] ws_target,
    input  logic        inst_req_fire,
    input  logic        inst_rsp,
    output logic        flush,
    output logic        discard_rsp,
    output logic        fetch_stall,
    output logic        redirect_valid,
    output logic [31:0] redirect_pc,
    input  logic        redirect_ack,
    output logic        busy
);

    // One extra bit so out_cnt plus a same-cycle request cannot wrap.
    localparam int DW = CNT_W + 1;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] out_cnt;
    logic [1:0]       state_q;
    logic [1:0]       state_d;
    logic [DW-1:0]    disc_cnt_q;
    logic [DW-1:0]    disc_cnt_d;
    logic [DW-1:0]    disc_init;
    logic [31:0]      tgt_r_q;
    logic [31:0]      tgt_r_d;
    logic             in_idle;
    logic             take_exc;

    inflight_counter #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING),
        .CNT_W          (CNT_W)
    ) u_inflight (
        .clk  (clk),
        .reset(reset),
        .fire (inst_req_fire),
        .rsp  (inst_rsp),
        .cnt  (out_cnt)
    );

    assign in_idle  = (state_q == EXR_IDLE);
    assign take_exc = in_idle && ws_exc_valid;

    // Responses still owed once this cycle's request/response settle.
    always_comb begin
        disc_init = {1'b0, out_cnt};
        if (inst_req_fire && !inst_rsp) begin
            disc_init = disc_init + DW'(1);
        end else if (inst_rsp && !inst_req_fire && out_cnt != '0) begin
            disc_init = disc_init - DW'(1);
        end
    end

    // Sequencer: IDLE -> (DRAIN) -> REDIRECT -> IDLE.
    always_comb begin
        state_d    = state_q;
        disc_cnt_d = disc_cnt_q;
        tgt_r_d    = tgt_r_q;
        case (state_q)
            EXR_IDLE: begin
                if (ws_exc_valid) begin
                    tgt_r_d    = ws_target;
                    disc_cnt_d = disc_init;
                    state_d    = (disc_init != '0) ? EXR_DRAIN
                                                   : EXR_REDIRECT;
                end
            end
            EXR_DRAIN: begin
                if (inst_rsp) begin
                    if (disc_cnt_q != '0) begin
                        disc_cnt_d = disc_cnt_q - DW'(1);
                    end
                    if (disc_cnt_q <= DW'(1)) begin
                        state_d = EXR_REDIRECT;
                    end
                end
            end
            EXR_REDIRECT: begin
                if (redirect_ack) begin
                    state_d = EXR_IDLE;
                end
            end
            default: begin
                state_d = EXR_IDLE;
            end
        endcase
    end

    // State, discard count and captured target.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= EXR_IDLE;
            disc_cnt_q <= '0;
            tgt_r_q    <= '0;
        end else begin
            state_q    <= state_d;
            disc_cnt_q <= disc_cnt_d;
            tgt_r_q    <= tgt_r_d;
        end
    end

    assign flush          = take_exc;
    assign discard_rsp    = inst_rsp &&
                            ((state_q == EXR_DRAIN) || take_exc);
    assign fetch_stall    = !in_idle || ws_exc_valid ||
                            (out_cnt == MAX_C);
    assign redirect_valid = (state_q == EXR_REDIRECT);
    assign redirect_pc    = redirect_valid ? tgt_r_q : 32'h0;
    assign busy           = !in_idle;

endmodule
